// File: rtl/read_batch_loader_pkg.sv
// Shared constants, state encoding and helpers for the read batch loader.
// Ports: none (package only).
package read_batch_loader_pkg;

    localparam int CL              = 512;
    localparam int READ_NUM_WIDTH  = 8;
    localparam int BS_W            = READ_NUM_WIDTH + 1;
    localparam int ADDR_W          = 64;
    localparam int MAX_OUTSTANDING = 16;
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W           = 11;
    localparam int LINES_PER_READ  = 4;
    localparam int HDR_BATCH_LSB   = 0;
    localparam int HDR_BATCH_MSB   = 8;

    localparam logic [BS_W-1:0]  MAX_READ = BS_W'(256);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_REQ,
        S_HDR_WAIT,
        S_STREAM,
        S_WAIT_DONE
    } state_t;

    // Number of lines that follow the header for a batch of n reads.
    function automatic logic [CNT_W-1:0] lines_for(input logic [BS_W-1:0] n);
        return CNT_W'(n) * CNT_W'(LINES_PER_READ);
    endfunction

endpackage

// File: rtl/loader_req_gen.sv
// Request generator: line address counter and outstanding-credit limiter.
// Ports: i_load (latch base), i_hdr_req/i_stream (phase), i_total, i_ready, i_rsp_ret -> o_req_valid, o_req_addr.
module loader_req_gen
    import read_batch_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_hdr_req,
    input  logic              i_stream,
    input  logic [CNT_W-1:0]  i_total,
    input  logic              i_ready,
    input  logic              i_rsp_ret,
    output logic              o_req_valid,
    output logic [ADDR_W-1:0] o_req_addr
);

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_req_cnt;
    logic [OUT_W-1:0]  r_out;
    logic              w_str_ok;
    logic              w_hs;
    logic              w_str_hs;

    // Valid depends only on registers and can only rise without a
    // handshake (credits returning), so a stalled request stays stable.
    assign w_str_ok    = i_stream && (r_req_cnt < i_total) && (r_out < MAX_OUT);
    assign o_req_valid = i_hdr_req || w_str_ok;
    assign o_req_addr  = r_addr;
    assign w_hs        = o_req_valid && i_ready;
    assign w_str_hs    = w_str_ok && i_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_req_cnt <= '0;
            r_out     <= '0;
        end else begin
            // Header sits at base; the address simply keeps counting
            // (and wraps) through the stream lines.
            if (i_load) begin
                r_addr    <= i_base_addr;
                r_req_cnt <= '0;
            end else if (w_hs) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_str_hs) begin
                r_req_cnt <= r_req_cnt + 1'b1;
            end
            if (i_load) begin
                r_out <= '0;
            end else if (w_str_hs && !i_rsp_ret) begin
                r_out <= r_out + 1'b1;
            end else if (!w_str_hs && i_rsp_ret && r_out != '0) begin
                r_out <= r_out - 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_batch_loader.sv
// Fetches a header plus 4 lines per read from host memory and streams them to the read RAM.
// Ports: start/base_addr in; busy/done/err out; rd_req_*/rd_rsp_* memory side; load_*/batch_size/load_done RAM side.
module read_batch_loader
    import read_batch_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_rd_req_valid,
    input  logic              i_rd_req_ready,
    output logic [ADDR_W-1:0] o_rd_req_addr,
    input  logic              i_rd_rsp_valid,
    input  logic [CL-1:0]     i_rd_rsp_data,
    output logic              o_load_valid,
    output logic [CL-1:0]     o_load_data,
    output logic [BS_W-1:0]   o_batch_size,
    input  logic              i_load_done
);

    state_t            r_state;
    logic              r_done;
    logic              r_err;
    logic              r_load_valid;
    logic [CL-1:0]     r_load_data;
    logic [BS_W-1:0]   r_batch_size;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_rsp_cnt;
    logic [OUT_W-1:0]  r_drain;

    logic              w_load;
    logic              w_fwd;
    logic              w_surplus;
    logic [BS_W-1:0]   w_hdr;
    logic              w_hdr_bad;

    assign w_load    = (r_state == S_IDLE) && i_start;
    assign w_fwd     = i_rd_rsp_valid && (r_state == S_STREAM);
    assign w_surplus = i_rd_rsp_valid &&
                       ((r_state == S_IDLE) ||
                        (r_state == S_HDR_REQ) ||
                        (r_state == S_WAIT_DONE));
    assign w_hdr     = i_rd_rsp_data[HDR_BATCH_MSB:HDR_BATCH_LSB];
    assign w_hdr_bad = (w_hdr == '0) || (w_hdr > MAX_READ);

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_load_valid = r_load_valid;
    assign o_load_data  = r_load_data;
    assign o_batch_size = r_batch_size;

    loader_req_gen u_req_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_base_addr (i_base_addr),
        .i_hdr_req   (r_state == S_HDR_REQ),
        .i_stream    (r_state == S_STREAM),
        .i_total     (r_total),
        .i_ready     (i_rd_req_ready),
        .i_rsp_ret   (w_fwd),
        .o_req_valid (o_rd_req_valid),
        .o_req_addr  (o_rd_req_addr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
            r_batch_size <= '0;
            r_total      <= '0;
            r_rsp_cnt    <= '0;
            r_drain      <= MAX_OUT;
        end else begin
            r_load_valid <= w_fwd;
            if (w_fwd) begin
                r_load_data <= i_rd_rsp_data;
            end
            // Requests in flight across a reset still come back; the
            // first MAX_OUTSTANDING responses are dropped silently.
            if (i_rd_rsp_valid && r_drain != '0) begin
                r_drain <= r_drain - 1'b1;
            end
            if (w_surplus && r_drain == '0) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_HDR_REQ;
                    end
                end
                S_HDR_REQ: begin
                    if (i_rd_req_ready) begin
                        r_state <= S_HDR_WAIT;
                    end
                end
                S_HDR_WAIT: begin
                    if (i_rd_rsp_valid) begin
                        if (w_hdr_bad) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_batch_size <= w_hdr;
                            r_total      <= lines_for(w_hdr);
                            r_rsp_cnt    <= '0;
                            r_state      <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_fwd) begin
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                        if (r_rsp_cnt + 1'b1 == r_total) begin
                            r_state <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (i_load_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_batch_loader.sv
// Scoreboard bench for read_batch_loader with a latency-programmable memory and read RAM model.
// Ports: none (top-level bench).
module tb_read_batch_loader;
    import read_batch_loader_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              i_start;
    logic [63:0]       i_base_addr;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_rd_req_valid;
    logic              i_rd_req_ready;
    logic [63:0]       o_rd_req_addr;
    logic              i_rd_rsp_valid;
    logic [511:0]      i_rd_rsp_data;
    logic              o_load_valid;
    logic [511:0]      o_load_data;
    logic [8:0]        o_batch_size;
    logic              i_load_done;

    typedef struct {
        logic [63:0]  addr;
        int           due;
        int           gen;
        logic [511:0] data;
        bit           hdr;
    } pend_t;

    pend_t        pend[$];
    logic [63:0]  exp_addr[$];
    logic [511:0] exp_data[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gen = 0;
    int g_lat = 0;
    int g_rmode = 0;
    int g_hdr_val = 0;
    int g_total = 0;
    int g_out = 0;
    int g_peak = 0;
    int ram_cnt = 0;
    int g_loads = 0;
    bit g_hdr_next = 0;
    bit ld_sent = 0;

    read_batch_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_rd_req_valid (o_rd_req_valid),
        .i_rd_req_ready (i_rd_req_ready),
        .o_rd_req_addr  (o_rd_req_addr),
        .i_rd_rsp_valid (i_rd_rsp_valid),
        .i_rd_rsp_data  (i_rd_rsp_data),
        .o_load_valid   (o_load_valid),
        .o_load_data    (o_load_data),
        .o_batch_size   (o_batch_size),
        .i_load_done    (i_load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mem_line(input logic [63:0] a);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) begin
            l[k*64 +: 64] = a ^ (64'h0101_0101_0101_0101 * 64'(k));
        end
        return l;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [63:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected", nm, act);
    endtask

    // Memory and read RAM model: decides inputs for the coming edge.
    always @(negedge clk) begin
        pend_t p;
        int    inc;
        int    dec;
        inc = 0;
        dec = 0;
        i_rd_rsp_valid = 1'b0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            i_rd_rsp_valid = 1'b1;
            i_rd_rsp_data  = p.data;
            if (p.gen == gen && !p.hdr) dec = 1;
        end
        i_rd_req_ready = (g_rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        i_load_done = 1'b0;
        if (!reset_n) begin
            gen++;
            g_out = 0;
            ram_cnt = 0;
        end else begin
            if (o_rd_req_valid && i_rd_req_ready) begin
                p.addr = o_rd_req_addr;
                p.due  = cyc + 1 + g_lat;
                p.gen  = gen;
                p.hdr  = g_hdr_next;
                p.data = mem_line(o_rd_req_addr);
                if (g_hdr_next) begin
                    p.data[8:0] = 9'(g_hdr_val);
                    g_hdr_next = 1'b0;
                end else begin
                    inc = 1;
                end
                pend.push_back(p);
            end
            g_out = g_out + inc - dec;
            if (g_out > g_peak) g_peak = g_out;
            if (o_load_valid) ram_cnt++;
            if (g_total != 0 && ram_cnt == g_total && !ld_sent) begin
                i_load_done = 1'b1;
                ld_sent = 1'b1;
            end
        end
        cyc++;
    end

    // Monitor: pops the scoreboard whenever the DUT presents something.
    bit          prev_stall = 0;
    bit          prev_ld = 0;
    logic [63:0] stall_addr = '0;
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            prev_stall = 0;
            prev_ld = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(o_rd_req_valid), 64'd1);
                chk("stall_addr", o_rd_req_addr, stall_addr);
            end
            if (o_rd_req_valid && i_rd_req_ready) begin
                if (exp_addr.size() == 0) extra("req_extra", o_rd_req_addr);
                else chk("req_addr", o_rd_req_addr, exp_addr.pop_front());
            end
            prev_stall = o_rd_req_valid && !i_rd_req_ready;
            stall_addr = o_rd_req_addr;
            if (o_load_valid) begin
                g_loads++;
                if (exp_data.size() == 0) extra("load_extra", o_load_data[63:0]);
                else chkw("load_data", o_load_data, exp_data.pop_front());
            end
            if (prev_ld) chk("done_after_load_done", 64'(o_done), 64'd1);
            if (i_load_done) chk("done_before_load_done", 64'(o_done), 64'd0);
            prev_ld = i_load_done;
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic start_batch(input logic [63:0] base, input int hdr,
                               input int lat, input int rmode);
        bit ok;
        ok = (hdr >= 1) && (hdr <= 256);
        g_lat = lat;
        g_rmode = rmode;
        g_hdr_val = hdr;
        g_hdr_next = 1'b1;
        g_peak = 0;
        ram_cnt = 0;
        ld_sent = 1'b0;
        g_loads = 0;
        g_total = ok ? 4 * hdr : 0;
        exp_addr.push_back(base);
        for (int i = 0; i < g_total; i++) begin
            exp_addr.push_back(base + 64'd1 + 64'(i));
            exp_data.push_back(mem_line(base + 64'd1 + 64'(i)));
        end
        i_base_addr = base;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic finish_batch(input bit ok, input logic [8:0] bs,
                                input bit peak16, input int loads);
        for (int c = 0; c < 20000 && !o_done; c++) step();
        chk("done", 64'(o_done), 64'd1);
        chk("busy_idle", 64'(o_busy), 64'd0);
        chk("err", 64'(o_err), 64'(!ok));
        chk("batch_size", 64'(o_batch_size), 64'(bs));
        step();
        step();
        chk("lines_left", 64'(exp_data.size()), 64'd0);
        chk("reqs_left", 64'(exp_addr.size()), 64'd0);
        chk("loads", 64'(g_loads), 64'(loads));
        chk("peak_cap", 64'(g_peak <= 16), 64'd1);
        if (peak16) chk("peak16", 64'(g_peak), 64'd16);
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        i_start = 1'b0;
        i_base_addr = '0;
        i_rd_req_ready = 1'b0;
        i_rd_rsp_valid = 1'b0;
        i_rd_rsp_data = '0;
        i_load_done = 1'b0;
        repeat (3) step();
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_req_valid", 64'(o_rd_req_valid), 64'd0);
        chk("rst_load_valid", 64'(o_load_valid), 64'd0);
        chk("rst_batch_size", 64'(o_batch_size), 64'd0);
        reset_n = 1'b1;
        step();

        // 1: small batch, zero-latency memory
        start_batch(64'h100, 3, 0, 0);
        finish_batch(1'b1, 9'd3, 1'b0, 12);

        // 2: largest batch, long latency, credit limit reached
        start_batch(64'h1_0000, 256, 40, 0);
        finish_batch(1'b1, 9'd256, 1'b1, 1024);

        // 3: illegal headers, batch_size keeps previous value
        start_batch(64'h5000, 0, 2, 0);
        finish_batch(1'b0, 9'd256, 1'b0, 0);
        start_batch(64'h6000, 257, 2, 0);
        finish_batch(1'b0, 9'd256, 1'b0, 0);

        // 4: random ready, response collides with requests
        start_batch(64'h7000, 5, 0, 1);
        finish_batch(1'b1, 9'd5, 1'b0, 20);

        // 5: address wrap: FFFE hdr, then FFFF, 0, 1, 2
        start_batch(64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0);
        finish_batch(1'b1, 9'd1, 1'b0, 4);

        // 6: reset with 10 stream requests in flight
        start_batch(64'h2000, 8, 20, 0);
        for (int c = 0; c < 300 && g_out != 10; c++) step();
        chk("inflight_before_reset", 64'(g_out), 64'd10);
        reset_n = 1'b0;
        step();
        step();
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_load_valid", 64'(o_load_valid), 64'd0);
        chk("mid_rst_batch_size", 64'(o_batch_size), 64'd0);
        g_total = 0;
        exp_addr.delete();
        exp_data.delete();
        reset_n = 1'b1;
        for (int c = 0; c < 300 && pend.size() != 0; c++) step();
        chk("stale_drained", 64'(pend.size()), 64'd0);
        repeat (3) step();
        chk("stale_no_err", 64'(o_err), 64'd0);
        start_batch(64'h3000, 2, 3, 0);
        finish_batch(1'b1, 9'd2, 1'b0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
